// File: rtl/inst_fetch_buf.sv
// Instruction fetch front end: issues word-aligned reads, buffers responses in order, feeds decode.
// Define IFETCH_BYPASS_EN to let a response reach decode in the same cycle when the FIFO is empty.
module inst_fetch_buf #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_in,
   input  logic          redirect,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [31:0]   mem_rdata,
   output logic          dec_valid,
   input  logic          dec_ready,
   output logic [31:0]   dec_inst,
   output logic [AW-1:0] dec_pc
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [31:0]   inst_mem [DEPTH];
   logic [AW-1:0] pc_mem   [DEPTH];

   logic          grant, resp, fifo_empty, bypass, push, pop;
   logic [CW:0]   used;
   logic [AW-1:0] new_pc;

   assign new_pc     = {pc_in[AW-1:2], 2'b00};
   assign fifo_empty = (count_q == '0);
   // Credits cover both buffered entries and requests still in flight, so the FIFO cannot overflow.
   assign used       = {1'b0, count_q} + {1'b0, outst_q};
   assign mem_req    = (state_q == FETCH) && (used < DEPTH_W);
   assign mem_addr   = fetch_pc_q;
   assign grant      = mem_req & mem_gnt;
   assign resp       = mem_rvalid && (outst_q != '0);

`ifdef IFETCH_BYPASS_EN
   assign bypass = fifo_empty && (state_q == FETCH) && resp;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      dec_valid = 1'b0;
      dec_inst  = '0;
      dec_pc    = '0;
      if (bypass) begin
         dec_valid = 1'b1;
         dec_inst  = mem_rdata;
         dec_pc    = resp_pc_q;
      end else if (!fifo_empty) begin
         dec_valid = 1'b1;
         dec_inst  = inst_mem[rd_ptr_q];
         dec_pc    = pc_mem[rd_ptr_q];
      end
   end

   // A bypassed response that decode takes right away never enters the FIFO.
   assign pop  = dec_valid && dec_ready && !bypass && !redirect;
   assign push = (state_q == FETCH) && resp && !redirect && !(bypass && dec_ready);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      discard_d  = discard_q;
      outst_d    = outst_q + CW'(grant) - CW'(resp);
      count_d    = count_q + CW'(push) - CW'(pop);
      if (grant) fetch_pc_d = fetch_pc_q + AW'(4);
      if ((state_q == FETCH) && resp) resp_pc_d = resp_pc_q + AW'(4);
      case (state_q)
         IDLE: if (redirect) state_d = FETCH;
         FETCH: ;
         DRAIN: begin
            if (resp) discard_d = discard_q - CW'(1);
            if (discard_d == '0) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
      if (redirect) begin
         fetch_pc_d = new_pc;
         resp_pc_d  = new_pc;
         count_d    = '0;
         discard_d  = outst_d;
         state_d    = (outst_d != '0) ? DRAIN : FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= '0;
         resp_pc_q  <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         discard_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr_q] <= mem_rdata;
         pc_mem[wr_ptr_q]   <= resp_pc_q;
      end
   end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Randomized bench for inst_fetch_buf against a queue-based memory and in-order stream model.
module tb_inst_fetch_buf;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] pc_in;
   logic          redirect;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;
   logic          dec_valid;
   logic          dec_ready;
   logic [31:0]   dec_inst;
   logic [AW-1:0] dec_pc;

   inst_fetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_in      (pc_in),
      .redirect   (redirect),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .dec_inst   (dec_inst),
      .dec_pc     (dec_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned rdy;
   } req_t;

   req_t        pend_q[$];
   int          n_vec, n_err;
   int unsigned cyc;
   int unsigned p_gnt, p_rv, p_rdy, p_redir, lat_max;
   bit          started, bypass_en;
   int          stale, grants_v, pops_v, resp_v;
   int          hs_cnt, gr_cnt;
   logic [31:0] exp_pc, exp_fetch;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic set_mode(input int unsigned g, input int unsigned v, input int unsigned r,
                           input int unsigned d, input int unsigned l);
      p_gnt = g; p_rv = v; p_rdy = r; p_redir = d; lat_max = l;
   endtask

   task automatic step(input bit force_redir, input logic [31:0] force_pc);
      bit hs, gr, rv, exp_req, exp_dv;
      int occ;
      @(negedge clk);
      redirect = force_redir || ($urandom_range(99) < p_redir);
      pc_in    = force_redir ? force_pc : $urandom;
      mem_gnt  = ($urandom_range(99) < p_gnt);
      if (pend_q.size() > 0 && pend_q[0].rdy <= cyc && $urandom_range(99) < p_rv) begin
         mem_rvalid = 1'b1;
         mem_rdata  = memf(pend_q[0].addr);
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
      end
      dec_ready = ($urandom_range(99) < p_rdy);
      #1;
      hs  = dec_valid & dec_ready;
      gr  = mem_req & mem_gnt;
      rv  = mem_rvalid;
      occ = resp_v - pops_v;
      exp_req = started && (stale == 0) && ((grants_v - pops_v) < int'(DEPTH));
      exp_dv  = started && (stale == 0) && (occ > 0 || (bypass_en && rv));
      check_eq("mem_req", 64'(mem_req), 64'(exp_req));
      check_eq("dec_valid", 64'(dec_valid), 64'(exp_dv));
      if (hs) begin
         check_eq("dec_pc", 64'(dec_pc), 64'(exp_pc));
         check_eq("dec_inst", 64'(dec_inst), 64'(memf(exp_pc)));
         exp_pc = exp_pc + 32'd4;
         pops_v++;
         hs_cnt++;
      end
      if (gr) begin
         check_eq("mem_addr", 64'(mem_addr), 64'(exp_fetch));
         pend_q.push_back('{addr: mem_addr, rdy: cyc + $urandom_range(lat_max, 1)});
         exp_fetch = exp_fetch + 32'd4;
         grants_v++;
         if (!redirect) gr_cnt++;
      end
      if (rv) begin
         void'(pend_q.pop_front());
         if (stale > 0) stale--;
         else resp_v++;
      end
      if (redirect) begin
         exp_pc    = {pc_in[31:2], 2'b00};
         exp_fetch = {pc_in[31:2], 2'b00};
         grants_v  = 0;
         pops_v    = 0;
         resp_v    = 0;
         stale     = pend_q.size();
         started   = 1'b1;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst        = 1'b0;
      redirect   = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      dec_ready  = 1'b0;
      #1;
      check_eq("rst_mem_req", 64'(mem_req), 64'd0);
      check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
      check_eq("rst_dec_valid", 64'(dec_valid), 64'd0);
      check_eq("rst_dec_inst", 64'(dec_inst), 64'd0);
      check_eq("rst_dec_pc", 64'(dec_pc), 64'd0);
      pend_q.delete();
      started  = 1'b0;
      stale    = 0;
      grants_v = 0;
      pops_v   = 0;
      resp_v   = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      redirect = 1'b0; pc_in = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      mem_rdata = '0; dec_ready = 1'b0;
      n_vec = 0; n_err = 0; cyc = 0; hs_cnt = 0; gr_cnt = 0;
      exp_pc = '0; exp_fetch = '0;
`ifdef IFETCH_BYPASS_EN
      bypass_en = 1'b1;
`else
      bypass_en = 1'b0;
`endif
      do_reset();

      // No fetching before the first redirect.
      set_mode(100, 100, 100, 0, 1);
      repeat (3) step(1'b0, '0);

      // Sequential fetch and full throughput.
      step(1'b1, 32'h0001_1223);
      repeat (4) step(1'b0, '0);
      hs_cnt = 0;
      repeat (20) step(1'b0, '0);
      check_eq("throughput", 64'(hs_cnt), 64'd20);

      // Decode stall fills exactly DEPTH credits.
      set_mode(100, 100, 0, 0, 1);
      step(1'b1, 32'h0000_4000);
      gr_cnt = 0;
      repeat (10) step(1'b0, '0);
      check_eq("stall_grants", 64'(gr_cnt), 64'(DEPTH));
      p_rdy = 100; hs_cnt = 0; gr_cnt = 0;
      repeat (4) step(1'b0, '0);
      check_eq("release_pops", 64'(hs_cnt), 64'd4);
      repeat (4) step(1'b0, '0);
      check_eq("refetch", 64'(gr_cnt > 0), 64'd1);

      // Redirect with three requests outstanding.
      set_mode(0, 100, 100, 0, 1);
      repeat (6) step(1'b0, '0);
      step(1'b1, 32'h0000_8000);
      set_mode(100, 0, 100, 0, 1);
      repeat (3) step(1'b0, '0);
      p_gnt = 0;
      step(1'b1, 32'h0000_0100);
      step(1'b0, '0);
      check_eq("drain_req", 64'(mem_req), 64'd0);
      set_mode(100, 100, 100, 0, 2);
      repeat (12) step(1'b0, '0);

      // Redirect coinciding with grant and response.
      set_mode(100, 100, 100, 0, 1);
      step(1'b1, 32'h0000_3000);
      repeat (5) step(1'b0, '0);
      step(1'b1, 32'h0000_2000);
      repeat (10) step(1'b0, '0);

      // Address wrap.
      step(1'b1, 32'hFFFF_FFF4);
      repeat (12) step(1'b0, '0);

      // Random traffic with a mid-stream reset.
      set_mode(70, 70, 60, 3, 3);
      repeat (1500) step(1'b0, '0);
      do_reset();
      repeat (3) step(1'b0, '0);
      repeat (1500) step(1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
